// File: rtl/eth_tx_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : eth_tx_arb_pkg                                           |
// | Description : Shared constants and types for the Ethernet transmit     |
// |               arbiter: header geometry and the arbiter FSM states.     |
// | Ports       : none (package)                                           |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
package eth_tx_arb_pkg;

  // Ethernet header: destination MAC + source MAC + ethertype.
  localparam int ETH_HDR_BYTES  = 14;
  localparam int ETH_MAC_WIDTH  = 48;
  localparam int ETH_TYPE_WIDTH = 16;

  // Arbiter ownership state.
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } arb_state_t;

endpackage : eth_tx_arb_pkg
`default_nettype wire

// File: rtl/eth_tx_arb_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : eth_rr_arbiter                                           |
// | Description : Combinational round-robin picker. Search starts at       |
// |               (last_grant+1) mod S_COUNT; the first requester found    |
// |               in that rotated order wins.                              |
// | Ports       : request     - per-source request vector                  |
// |               enable      - allow a grant this cycle                   |
// |               last_grant  - index of the previous owner                |
// |               grant       - one-hot winner                             |
// |               grant_index - binary winner index                        |
// |               grant_valid - a winner exists                            |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module eth_rr_arbiter
  import eth_tx_arb_pkg::*;
#(
  parameter int S_COUNT = 4,
  parameter int IDX_W   = $clog2(S_COUNT)
) (
  input  logic [S_COUNT-1:0] request,
  input  logic               enable,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [S_COUNT-1:0] grant,
  output logic [IDX_W-1:0]   grant_index,
  output logic               grant_valid
);

  // One extra bit so last_grant + offset cannot overflow before the wrap.
  logic [IDX_W:0] w_cand;

  always_comb begin
    grant       = '0;
    grant_index = '0;
    grant_valid = 1'b0;
    w_cand      = '0;
    for (int k = 1; k <= S_COUNT; k++) begin
      w_cand = {1'b0, last_grant} + (IDX_W+1)'(k);
      if (w_cand >= (IDX_W+1)'(S_COUNT)) begin
        w_cand = w_cand - (IDX_W+1)'(S_COUNT);
      end
      if (enable && !grant_valid && request[w_cand[IDX_W-1:0]]) begin
        grant_valid                  = 1'b1;
        grant_index                  = w_cand[IDX_W-1:0];
        grant[w_cand[IDX_W-1:0]]     = 1'b1;
      end
    end
  end

endmodule : eth_rr_arbiter
`default_nettype wire

// File: rtl/eth_tx_arb.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : eth_tx_arb                                               |
// | Description : Round-robin arbiter sharing one Ethernet transmitter     |
// |               between S_COUNT frame sources. The header of the winner  |
// |               is registered; its payload is muxed combinationally for  |
// |               the length of the frame.                                 |
// | Ports       : clk, rst                 - clock, sync active-high reset |
// |               s_eth_hdr_*              - per-source header handshake   |
// |               s_eth_payload_axis_*     - per-source payload streams    |
// |               m_eth_hdr_*              - header to transmitter         |
// |               m_eth_payload_axis_*     - payload to transmitter        |
// |               grant_valid/grant_index  - current owner                 |
// |               busy                     - owner present or request seen |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module eth_tx_arb
  import eth_tx_arb_pkg::*;
#(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH/8
) (
  input  logic                           clk,
  input  logic                           rst,

  input  logic [S_COUNT-1:0]             s_eth_hdr_valid,
  output logic [S_COUNT-1:0]             s_eth_hdr_ready,
  input  logic [S_COUNT*48-1:0]          s_eth_dest_mac,
  input  logic [S_COUNT*48-1:0]          s_eth_src_mac,
  input  logic [S_COUNT*16-1:0]          s_eth_type,
  input  logic [S_COUNT*DATA_WIDTH-1:0]  s_eth_payload_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0]  s_eth_payload_axis_tkeep,
  input  logic [S_COUNT-1:0]             s_eth_payload_axis_tvalid,
  output logic [S_COUNT-1:0]             s_eth_payload_axis_tready,
  input  logic [S_COUNT-1:0]             s_eth_payload_axis_tlast,
  input  logic [S_COUNT-1:0]             s_eth_payload_axis_tuser,

  output logic                           m_eth_hdr_valid,
  input  logic                           m_eth_hdr_ready,
  output logic [47:0]                    m_eth_dest_mac,
  output logic [47:0]                    m_eth_src_mac,
  output logic [15:0]                    m_eth_type,
  output logic [DATA_WIDTH-1:0]          m_eth_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0]          m_eth_payload_axis_tkeep,
  output logic                           m_eth_payload_axis_tvalid,
  input  logic                           m_eth_payload_axis_tready,
  output logic                           m_eth_payload_axis_tlast,
  output logic                           m_eth_payload_axis_tuser,

  output logic                           grant_valid,
  output logic [$clog2(S_COUNT)-1:0]     grant_index,
  output logic                           busy
);

  localparam int IDX_W = $clog2(S_COUNT);

  // ---------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------
  arb_state_t                r_state;
  logic [IDX_W-1:0]          r_owner;
  logic [IDX_W-1:0]          r_last_grant;
  logic                      r_hdr_done;
  logic                      r_pay_done;
  logic                      r_hdr_valid;
  logic [ETH_MAC_WIDTH-1:0]  r_dest_mac;
  logic [ETH_MAC_WIDTH-1:0]  r_src_mac;
  logic [ETH_TYPE_WIDTH-1:0] r_type;

  // ---------------------------------------------------------------------
  // Per-source views of the flattened input buses
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]     w_src_tdata [S_COUNT];
  logic [KEEP_WIDTH-1:0]     w_src_tkeep [S_COUNT];
  logic [ETH_MAC_WIDTH-1:0]  w_src_dest  [S_COUNT];
  logic [ETH_MAC_WIDTH-1:0]  w_src_src   [S_COUNT];
  logic [ETH_TYPE_WIDTH-1:0] w_src_type  [S_COUNT];

  logic [S_COUNT-1:0]        w_arb_grant;
  logic [IDX_W-1:0]          w_arb_index;
  logic                      w_arb_valid;
  logic                      w_arb_enable;
  logic                      w_pay_en;
  logic                      w_hdr_fire;
  logic                      w_last_fire;
  logic                      w_hdr_done_nx;
  logic                      w_pay_done_nx;

  generate
    for (genvar gi = 0; gi < S_COUNT; gi++) begin : g_src
      assign w_src_tdata[gi] = s_eth_payload_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign w_src_tkeep[gi] = s_eth_payload_axis_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH];
      assign w_src_dest[gi]  = s_eth_dest_mac[gi*ETH_MAC_WIDTH +: ETH_MAC_WIDTH];
      assign w_src_src[gi]   = s_eth_src_mac[gi*ETH_MAC_WIDTH +: ETH_MAC_WIDTH];
      assign w_src_type[gi]  = s_eth_type[gi*ETH_TYPE_WIDTH +: ETH_TYPE_WIDTH];
      // Only the owner sees the transmitter's ready.
      assign s_eth_payload_axis_tready[gi] = w_pay_en && (r_owner == IDX_W'(gi))
                                             && m_eth_payload_axis_tready;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Arbitration: only evaluated while idle and out of reset, so the
  // winner's hdr_ready pulse coincides exactly with the header capture.
  // ---------------------------------------------------------------------
  assign w_arb_enable = (r_state == ST_IDLE) && !rst;

  eth_rr_arbiter #(
    .S_COUNT (S_COUNT),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .request     (s_eth_hdr_valid),
    .enable      (w_arb_enable),
    .last_grant  (r_last_grant),
    .grant       (w_arb_grant),
    .grant_index (w_arb_index),
    .grant_valid (w_arb_valid)
  );

  assign s_eth_hdr_ready = w_arb_grant;

  // Payload passes only until the owner's tlast beat. Once that beat is
  // taken, anything the owner presents belongs to its next frame and is
  // held back until that frame is granted. Reset closes the path at once.
  assign w_pay_en    = (r_state == ST_ACTIVE) && !r_pay_done && !rst;
  assign w_hdr_fire  = r_hdr_valid && m_eth_hdr_ready;
  assign w_last_fire = m_eth_payload_axis_tvalid && m_eth_payload_axis_tready
                       && m_eth_payload_axis_tlast;

  // Completion seen so far including this cycle, so a header accept and
  // the tlast beat landing together still release on this edge.
  assign w_hdr_done_nx = r_hdr_done || w_hdr_fire;
  assign w_pay_done_nx = r_pay_done || w_last_fire;

  // ---------------------------------------------------------------------
  // Ownership FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_last_grant <= IDX_W'(S_COUNT-1);
      r_hdr_done   <= 1'b0;
      r_pay_done   <= 1'b0;
      r_hdr_valid  <= 1'b0;
      r_dest_mac   <= '0;
      r_src_mac    <= '0;
      r_type       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_arb_valid) begin
            r_state     <= ST_ACTIVE;
            r_owner     <= w_arb_index;
            r_hdr_valid <= 1'b1;
            r_dest_mac  <= w_src_dest[w_arb_index];
            r_src_mac   <= w_src_src[w_arb_index];
            r_type      <= w_src_type[w_arb_index];
            r_hdr_done  <= 1'b0;
            r_pay_done  <= 1'b0;
          end
        end

        ST_ACTIVE: begin
          if (w_hdr_fire) begin
            r_hdr_valid <= 1'b0;
          end
          if (w_hdr_done_nx && w_pay_done_nx) begin
            r_state      <= ST_IDLE;
            r_last_grant <= r_owner;
            r_hdr_done   <= 1'b0;
            r_pay_done   <= 1'b0;
          end else begin
            r_hdr_done   <= w_hdr_done_nx;
            r_pay_done   <= w_pay_done_nx;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign m_eth_hdr_valid = r_hdr_valid;
  assign m_eth_dest_mac  = r_dest_mac;
  assign m_eth_src_mac   = r_src_mac;
  assign m_eth_type      = r_type;

  assign m_eth_payload_axis_tdata  = w_src_tdata[r_owner];
  assign m_eth_payload_axis_tkeep  = w_src_tkeep[r_owner];
  assign m_eth_payload_axis_tlast  = s_eth_payload_axis_tlast[r_owner];
  assign m_eth_payload_axis_tuser  = s_eth_payload_axis_tuser[r_owner];
  assign m_eth_payload_axis_tvalid = w_pay_en && s_eth_payload_axis_tvalid[r_owner];

  assign grant_valid = (r_state == ST_ACTIVE);
  assign grant_index = r_owner;
  assign busy        = (r_state == ST_ACTIVE) || (|s_eth_hdr_valid);

endmodule : eth_tx_arb
`default_nettype wire

// File: tb/tb_eth_tx_arb.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_eth_tx_arb                                            |
// | Description : Self-checking bench for eth_tx_arb. Bench-side sources   |
// |               send generated frames; a cycle-level reference model     |
// |               predicts ownership, handshakes and output contents.      |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_eth_tx_arb;

  localparam int S     = 4;
  localparam int DW    = 8;
  localparam int KW    = 1;
  localparam int IW    = 2;
  localparam int MAXF  = 64;
  localparam int STALL = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic [S-1:0]    s_hdr_valid, s_hdr_ready;
  logic [S*48-1:0] s_dest, s_src;
  logic [S*16-1:0] s_type;
  logic [S*DW-1:0] s_tdata;
  logic [S*KW-1:0] s_tkeep;
  logic [S-1:0]    s_tvalid, s_tready, s_tlast, s_tuser;
  logic            m_hdr_valid, m_hdr_ready;
  logic [47:0]     m_dest, m_src;
  logic [15:0]     m_type;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic            m_tvalid, m_tready, m_tlast, m_tuser;
  logic            grant_valid;
  logic [IW-1:0]   grant_index;
  logic            busy;

  eth_tx_arb #(.S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .s_eth_hdr_valid           (s_hdr_valid),
    .s_eth_hdr_ready           (s_hdr_ready),
    .s_eth_dest_mac            (s_dest),
    .s_eth_src_mac             (s_src),
    .s_eth_type                (s_type),
    .s_eth_payload_axis_tdata  (s_tdata),
    .s_eth_payload_axis_tkeep  (s_tkeep),
    .s_eth_payload_axis_tvalid (s_tvalid),
    .s_eth_payload_axis_tready (s_tready),
    .s_eth_payload_axis_tlast  (s_tlast),
    .s_eth_payload_axis_tuser  (s_tuser),
    .m_eth_hdr_valid           (m_hdr_valid),
    .m_eth_hdr_ready           (m_hdr_ready),
    .m_eth_dest_mac            (m_dest),
    .m_eth_src_mac             (m_src),
    .m_eth_type                (m_type),
    .m_eth_payload_axis_tdata  (m_tdata),
    .m_eth_payload_axis_tkeep  (m_tkeep),
    .m_eth_payload_axis_tvalid (m_tvalid),
    .m_eth_payload_axis_tready (m_tready),
    .m_eth_payload_axis_tlast  (m_tlast),
    .m_eth_payload_axis_tuser  (m_tuser),
    .grant_valid               (grant_valid),
    .grant_index               (grant_index),
    .busy                      (busy)
  );

  always #5 clk = ~clk;

  // Frame store (source side) and scoreboard / model state.
  logic [47:0] f_dest [S][MAXF];
  logic [47:0] f_src  [S][MAXF];
  logic [15:0] f_type [S][MAXF];
  int          f_len  [S][MAXF];
  logic        f_user [S][MAXF];
  int n_frames [S];
  int hdr_ptr  [S];
  int pay_ptr  [S];
  int beat_ptr [S];
  int exp_hdr  [S];
  int exp_pay  [S];
  int exp_beat [S];
  int grants   [S];
  int grant_seq[$];
  int model_last, model_owner, act_cnt;
  logic model_active, cur_hdr_seen, cur_last_seen, fair_chk;
  int hdr_mode, tready_pct, salt;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pbyte(input int s, input int f, input int b);
    return 8'((s*97 + f*31 + b*13 + salt) % 256);
  endfunction

  // Round-robin rule: search from last+1, wrapping, first requester wins.
  function automatic int rr_pick(input logic [S-1:0] req, input int last);
    for (int k = 1; k <= S; k++) begin
      if (req[(last + k) % S]) return (last + k) % S;
    end
    return -1;
  endfunction

  task automatic model_reset();
    model_active  = 1'b0;
    model_last    = S-1;
    model_owner   = 0;
    cur_hdr_seen  = 1'b0;
    cur_last_seen = 1'b0;
    act_cnt       = 0;
  endtask

  task automatic drive_sources();
    for (int s = 0; s < S; s++) begin
      int h, p;
      h = (hdr_ptr[s] < MAXF) ? hdr_ptr[s] : MAXF-1;
      p = (pay_ptr[s] < MAXF) ? pay_ptr[s] : MAXF-1;
      s_hdr_valid[s]       = hdr_ptr[s] < n_frames[s];
      s_dest[s*48 +: 48]   = f_dest[s][h];
      s_src[s*48 +: 48]    = f_src[s][h];
      s_type[s*16 +: 16]   = f_type[s][h];
      s_tvalid[s]          = pay_ptr[s] < n_frames[s];
      s_tdata[s*DW +: DW]  = pbyte(s, p, beat_ptr[s]);
      s_tkeep[s*KW +: KW]  = '1;
      s_tlast[s]           = beat_ptr[s] == f_len[s][p] - 1;
      s_tuser[s]           = f_user[s][p];
    end
  endtask

  task automatic load(input int nf0, input int nf1, input int nf2, input int nf3,
                      input int minlen, input int maxlen);
    int nf [S];
    nf = '{nf0, nf1, nf2, nf3};
    for (int s = 0; s < S; s++) begin
      n_frames[s] = nf[s];
      hdr_ptr[s] = 0; pay_ptr[s] = 0; beat_ptr[s] = 0;
      exp_hdr[s] = 0; exp_pay[s] = 0; exp_beat[s] = 0; grants[s] = 0;
      for (int f = 0; f < MAXF; f++) begin
        f_dest[s][f] = 48'({$urandom, $urandom});
        f_src[s][f]  = 48'({$urandom, $urandom});
        f_type[s][f] = 16'($urandom);
        f_len[s][f]  = $urandom_range(maxlen, minlen);
        f_user[s][f] = 1'($urandom);
      end
    end
    grant_seq.delete();
    drive_sources();
  endtask

  // Reference model: evaluated once per cycle on the falling edge.
  task automatic monitor();
    logic [S-1:0] req, exp_hrdy, exp_trdy, own_bit;
    logic exp_hv, exp_tv, exp_last;
    int w, o, f, h, mx, mn;
    req = s_hdr_valid;
    o = model_owner;
    w = rr_pick(req, model_last);
    own_bit = '0; own_bit[o] = 1'b1;
    exp_hrdy = '0;
    if (!model_active && w >= 0) exp_hrdy[w] = 1'b1;
    exp_hv   = model_active && !cur_hdr_seen;
    exp_tv   = model_active && !cur_last_seen && s_tvalid[o];
    exp_trdy = (model_active && !cur_last_seen && m_tready) ? own_bit : '0;

    chk("grant_valid", grant_valid, model_active);
    if (model_active) chk("grant_index", grant_index, o);
    chk("busy", busy, model_active || (|req));
    chk("s_hdr_ready", s_hdr_ready, exp_hrdy);
    chk("s_tready", s_tready, exp_trdy);
    chk("m_hdr_valid", m_hdr_valid, exp_hv);
    chk("m_tvalid", m_tvalid, exp_tv);

    if (exp_hv) begin
      h = exp_hdr[o];
      chk("hdr_dest", m_dest, f_dest[o][h]);
      chk("hdr_src", m_src, f_src[o][h]);
      chk("hdr_type", m_type, f_type[o][h]);
      if (m_hdr_ready) begin
        cur_hdr_seen = 1'b1;
        exp_hdr[o]++;
      end
    end
    if (exp_tv) begin
      f = exp_pay[o];
      exp_last = exp_beat[o] == f_len[o][f] - 1;
      chk("pay_data", m_tdata, pbyte(o, f, exp_beat[o]));
      chk("pay_last", m_tlast, exp_last);
      chk("pay_user", m_tuser, f_user[o][f]);
      chk("pay_keep", m_tkeep, 1);
      if (m_tready) begin
        if (exp_last) begin
          cur_last_seen = 1'b1;
          exp_pay[o]++;
          exp_beat[o] = 0;
        end else begin
          exp_beat[o]++;
        end
      end
    end

    if (model_active) begin
      act_cnt++;
      if (cur_hdr_seen && cur_last_seen) begin
        model_active = 1'b0;
        model_last   = o;
      end
    end else begin
      act_cnt = 0;
      if (w >= 0) begin
        model_active  = 1'b1;
        model_owner   = w;
        cur_hdr_seen  = 1'b0;
        cur_last_seen = 1'b0;
        grants[w]++;
        grant_seq.push_back(w);
        if (fair_chk) begin
          mx = grants[0]; mn = grants[0];
          for (int s = 1; s < S; s++) begin
            if (grants[s] > mx) mx = grants[s];
            if (grants[s] < mn) mn = grants[s];
          end
          chk("fairness", (mx - mn) <= 1, 1);
        end
      end
    end
  endtask

  task automatic cycle();
    logic [S-1:0] hf, pf, lb;
    @(negedge clk);
    hf = s_hdr_valid & s_hdr_ready;
    pf = s_tvalid & s_tready;
    lb = s_tlast;
    if (rst) model_reset();
    else     monitor();
    @(posedge clk); #1;
    for (int s = 0; s < S; s++) begin
      if (hf[s]) hdr_ptr[s]++;
      if (pf[s]) begin
        if (lb[s]) begin
          beat_ptr[s] = 0;
          pay_ptr[s]++;
        end else begin
          beat_ptr[s]++;
        end
      end
    end
    m_tready = $urandom_range(99, 0) < tready_pct;
    case (hdr_mode)
      1:       m_hdr_ready = $urandom_range(99, 0) < 60;
      2:       m_hdr_ready = act_cnt >= STALL;
      default: m_hdr_ready = 1'b1;
    endcase
    drive_sources();
  endtask

  function automatic logic all_done();
    for (int s = 0; s < S; s++) begin
      if (exp_hdr[s] != n_frames[s] || exp_pay[s] != n_frames[s]) return 1'b0;
    end
    return !model_active;
  endfunction

  task automatic run(input string tag, input int budget);
    int c;
    c = 0;
    while (!all_done() && c < budget) begin
      cycle();
      c++;
    end
    chk(tag, all_done(), 1);
    cycle();
    cycle();
  endtask

  initial begin
    salt = $urandom_range(255, 0);
    fair_chk = 1'b0; hdr_mode = 0; tready_pct = 100;
    m_hdr_ready = 1'b1; m_tready = 1'b1;
    rst = 1'b1;
    load(0, 0, 0, 0, 1, 1);
    model_reset();

    // Reset state.
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_m_hdr_valid", m_hdr_valid, 0);
    chk("rst_m_dest", m_dest, 0);
    chk("rst_m_src", m_src, 0);
    chk("rst_m_type", m_type, 0);
    chk("rst_hdr_ready", s_hdr_ready, 0);
    chk("rst_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cycle();

    // All four request at once, 3-beat frames: grants 0,1,2,3.
    load(1, 1, 1, 1, 3, 3);
    run("timeout_all4", 200);
    chk("all4_count", grant_seq.size(), 4);
    for (int i = 0; i < 4 && i < grant_seq.size(); i++) chk("all4_order", grant_seq[i], i);

    // Lone source 2, five frames back to back.
    load(0, 0, 5, 0, 2, 6);
    run("timeout_lone", 300);
    chk("lone_count", grants[2], 5);
    for (int i = 0; i < grant_seq.size(); i++) chk("lone_owner", grant_seq[i], 2);

    // Header stalled for STALL cycles; owner's single beat ends before the
    // header is accepted; source 3 requests mid-frame.
    hdr_mode = 2;
    load(2, 0, 0, 1, 1, 1);
    run("timeout_stall", 300);
    chk("stall_grants0", grants[0], 2);
    chk("stall_grants3", grants[3], 1);
    hdr_mode = 0;

    // Random throttling, 200 frames, strict fairness.
    hdr_mode = 1; tready_pct = 50; fair_chk = 1'b1;
    load(50, 50, 50, 50, 1, 6);
    run("timeout_random", 12000);
    for (int s = 0; s < S; s++) chk("random_grants", grants[s], 50);
    hdr_mode = 0; tready_pct = 100; fair_chk = 1'b0;

    // Reset in the middle of source 1's payload.
    load(0, 1, 0, 0, 8, 8);
    begin
      int c;
      c = 0;
      while (!(model_active && model_owner == 1 && exp_beat[1] >= 2) && c < 100) begin
        cycle();
        c++;
      end
      chk("reach_mid_frame", c < 100, 1);
    end
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_grant_valid", grant_valid, 0);
    chk("midrst_hdr_ready", s_hdr_ready, 0);
    chk("midrst_tready", s_tready, 0);
    chk("midrst_m_tvalid", m_tvalid, 0);
    chk("midrst_m_hdr_valid", m_hdr_valid, 0);
    @(posedge clk); #1;
    model_reset();
    load(1, 1, 1, 1, 2, 2);
    rst = 1'b0;
    run("timeout_post_rst", 200);
    chk("post_rst_count", grant_seq.size(), 4);
    if (grant_seq.size() > 0) chk("post_rst_first", grant_seq[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_eth_tx_arb
`default_nettype wire

// File: doc/eth_tx_arb.md
ETH_TX_ARB -- requirements
Module: eth_tx_arb

Interface
REQ-001 Parameter S_COUNT, default 4, number of Ethernet frame sources sharing one transmitter; range 2..16.
REQ-002 Parameter DATA_WIDTH, default 8, payload AXI-stream data width in bits; multiple of 8.
REQ-003 Parameter KEEP_WIDTH, default DATA_WIDTH/8, tkeep width.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 s_eth_hdr_valid / s_eth_hdr_ready  in/out  S_COUNT each  per-source header handshake.
REQ-007 s_eth_dest_mac, s_eth_src_mac  in  S_COUNT*48 each  per-source MACs; source i occupies bits [i*48 +: 48].
REQ-008 s_eth_type  in  S_COUNT*16  per-source ethertype.
REQ-009 s_eth_payload_axis_tdata/tkeep  in  S_COUNT*DATA_WIDTH / S_COUNT*KEEP_WIDTH  per-source payload.
REQ-010 s_eth_payload_axis_tvalid, tlast, tuser  in  S_COUNT each; tready  out  S_COUNT.
REQ-011 m_eth_hdr_valid  out  1; m_eth_hdr_ready  in  1; m_eth_dest_mac, m_eth_src_mac  out  48; m_eth_type  out  16  header to transmitter.
REQ-012 m_eth_payload_axis_tdata/tkeep/tvalid/tlast/tuser  out; tready  in  payload to transmitter.
REQ-013 grant_valid  out  1; grant_index  out  $clog2(S_COUNT)  current owner; busy  out  1.

Function
REQ-014 FSM states IDLE, ACTIVE; exactly one source owns the output while ACTIVE.
REQ-015 IDLE: if any s_eth_hdr_valid, select winner round-robin, starting from (last_grant+1) mod S_COUNT, lowest index after that wins; enter ACTIVE next cycle.
REQ-016 Header path registered: winner's header captured on entry to ACTIVE; m_eth_hdr_valid high first ACTIVE cycle, one cycle after the arbitration decision.
REQ-017 s_eth_hdr_ready[winner] pulses for exactly the capture cycle; all other s_eth_hdr_ready low at all times.
REQ-018 m_eth_hdr_valid held with stable fields until m_eth_hdr_ready; then deasserts; hdr_done flag set.
REQ-019 Payload path combinational mux of owner while ACTIVE: m_payload fields = owner's; s_eth_payload_axis_tready[owner] = m_eth_payload_axis_tready; non-owners tready low; m tvalid low in IDLE.
REQ-020 Payload transfer with tlast sets pay_done; payload beats accepted before header accepted are legal.
REQ-021 Release: when hdr_done and pay_done both true (including same-cycle header accept and tlast beat), return to IDLE next cycle, last_grant <= owner, flags clear.
REQ-022 Minimum frame-to-frame gap: one IDLE cycle; back-to-back winners from different sources on consecutive frames when all request.
REQ-023 Single requester repeatedly requesting is re-granted every frame (no starvation of lone source).
REQ-024 grant_valid = (state==ACTIVE); grant_index = owner, held stable for whole frame; busy = grant_valid or any s_eth_hdr_valid.
REQ-025 Requests arriving mid-frame do not alter owner; tuser passed through unmodified.

Reset
REQ-026 On rst: state IDLE, last_grant = S_COUNT-1 (port 0 highest priority first), flags clear, all outputs valid/ready low, header regs 0.
REQ-027 rst mid-frame: ownership dropped next cycle; in-flight frame truncated at output without tlast; sources not acknowledged further.

Structure
REQ-028 Shared package holds ETH_HDR_BYTES=14, MAC width 48, ethertype width 16, FSM state enumeration.
REQ-029 One sub-module: eth_rr_arbiter (request vector, enable, last_grant in; one-hot grant and index out), purely combinational.

Verification
REQ-030 Reset, all 4 sources request simultaneously, 3-beat frames -> grants 0,1,2,3 in order, each header MACs/type match source, 1 IDLE cycle between.
REQ-031 Source 2 only, 5 frames back-to-back -> grant_index=2 each frame, no gaps beyond 1 cycle, data byte-exact.
REQ-032 m_eth_hdr_ready held low 10 cycles after grant -> m_eth_hdr_valid and fields stable 10 cycles, payload tready to other sources stays 0.
REQ-033 Owner sends tlast before header accepted -> grant held until header accept, then IDLE next cycle.
REQ-034 Random m_eth_payload_axis_tready throttling (50%) over 200 frames, 4 sources -> no data loss/reorder per source, grant counts differ by at most 1.
REQ-035 rst asserted mid-payload of source 1 -> next cycle grant_valid=0, all ready=0; first post-reset grant goes to port 0.
